// File: rtl/vita49_pkg.sv
// ============================================================================
// Module      : vita49_pkg
// Description : Shared constants for the VITA-49 timed-transmit gate.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vita49_pkg;

    localparam int TSF_W = 64;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_HDR_LO = 3'd1;
    localparam logic [2:0] ST_CHECK  = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_STREAM = 3'd4;
    localparam logic [2:0] ST_DROP   = 3'd5;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_FLUSH  = 1;

    localparam int STAT_STATE_LSB = 0;
    localparam int STAT_BUSY      = 3;
    localparam int STAT_ERR_LSB   = 8;
    localparam int STAT_LATE_LSB  = 16;

endpackage

`default_nettype wire

// File: rtl/vita49_ts_cmp.sv
// ============================================================================
// Module      : vita49_ts_cmp
// Description : Registers the local TSF and classifies a packet timestamp
//               against it as late, on time or too far ahead.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vita49_ts_cmp
    import vita49_pkg::*;
#(
    parameter int unsigned      LEAD      = 2,
    parameter logic [TSF_W-1:0] MAX_AHEAD = 64'h0000_0000_1000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [TSF_W-1:0] tsf,
    input  logic [TSF_W-1:0] pkt_ts,
    output logic             late,
    output logic             on_time,
    output logic             too_early
);

    localparam logic [TSF_W:0] LEAD_X = (TSF_W + 1)'(LEAD);

    logic [TSF_W-1:0] tsf_r;
    logic [TSF_W:0]   diff;

    always_ff @(posedge clk) begin
        if (rst) begin
            tsf_r <= '0;
        end else begin
            tsf_r <= tsf;
        end
    end

    // One extra bit so the subtraction borrow becomes the "late" sign.
    assign diff      = {1'b0, pkt_ts} - ({1'b0, tsf_r} + LEAD_X);
    assign late      = diff[TSF_W];
    assign on_time   = (diff == '0);
    assign too_early = !late && (diff[TSF_W-1:0] > MAX_AHEAD);

endmodule

`default_nettype wire

// File: rtl/vita49_tx_timegate.sv
// ============================================================================
// Module      : vita49_tx_timegate
// Description : Holds each timestamped AXI-Stream packet until the local TSF
//               reaches its timestamp, then passes the payload through.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vita49_tx_timegate
    import vita49_pkg::*;
#(
    parameter int unsigned      LEAD      = 2,
    parameter logic [TSF_W-1:0] MAX_AHEAD = 64'h0000_0000_1000_0000,
    parameter bit               LATE_MODE = 1'b0
) (
    input  logic             samp_clk,
    input  logic             RESET,
    input  logic [31:0]      ctrl,
    input  logic [TSF_W-1:0] tsf,
    input  logic [31:0]      s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tlast,
    output logic [31:0]      m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic [31:0]      status,
    output logic [31:0]      pkt_cnt
);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [TSF_W-1:0] pkt_ts;
    logic [7:0]       err_cnt;
    logic [15:0]      late_cnt;
    logic             enable;
    logic             flush;
    logic             late;
    logic             on_time;
    logic             too_early;
    logic             pass;
    logic             s_ready;
    logic             acc;
    logic             err_inc;
    logic             late_inc;
    logic             pkt_inc;
    logic             ctrl_unused;

    assign enable      = ctrl[CTRL_ENABLE];
    assign flush       = ctrl[CTRL_FLUSH];
    assign ctrl_unused = ^ctrl[31:2];

    vita49_ts_cmp #(
        .LEAD      (LEAD),
        .MAX_AHEAD (MAX_AHEAD)
    ) u_ts_cmp (
        .clk       (samp_clk),
        .rst       (RESET),
        .tsf       (tsf),
        .pkt_ts    (pkt_ts),
        .late      (late),
        .on_time   (on_time),
        .too_early (too_early)
    );

    // WAIT passes data in the very cycle the deadline is met, so the first
    // word leaves with tsf_r + LEAD == pkt_ts rather than one cycle later.
    assign pass = !RESET && !flush &&
                  ((state == ST_STREAM) || ((state == ST_WAIT) && (late || on_time)));

    always_comb begin
        s_ready = 1'b0;
        if (!RESET) begin
            case (state)
                ST_IDLE:   s_ready = enable;
                ST_HDR_LO: s_ready = !flush;
                ST_DROP:   s_ready = 1'b1;
                default:   s_ready = pass && m_axis_tready;
            endcase
        end
    end

    assign s_axis_tready = s_ready;
    assign acc           = s_axis_tvalid && s_ready;
    assign m_axis_tvalid = pass && s_axis_tvalid;
    assign m_axis_tdata  = pass ? s_axis_tdata : 32'd0;
    assign m_axis_tlast  = pass && s_axis_tlast;

    always_comb begin
        state_nxt = state;
        err_inc   = 1'b0;
        late_inc  = 1'b0;
        pkt_inc   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (acc && s_axis_tlast) begin
                    err_inc = 1'b1;
                end else if (acc) begin
                    state_nxt = ST_HDR_LO;
                end
            end
            ST_HDR_LO: begin
                if (flush) begin
                    state_nxt = ST_DROP;
                end else if (acc && s_axis_tlast) begin
                    err_inc   = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (acc) begin
                    state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (flush) begin
                    state_nxt = ST_DROP;
                end else if (late) begin
                    late_inc  = 1'b1;
                    state_nxt = LATE_MODE ? ST_STREAM : ST_DROP;
                end else if (too_early) begin
                    err_inc   = 1'b1;
                    state_nxt = ST_DROP;
                end else if (on_time) begin
                    state_nxt = ST_STREAM;
                end else begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT, ST_STREAM: begin
                if (flush) begin
                    state_nxt = ST_DROP;
                end else if (pass && acc && s_axis_tlast) begin
                    pkt_inc   = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (pass) begin
                    state_nxt = ST_STREAM;
                end
            end
            ST_DROP: begin
                if (acc && s_axis_tlast) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge samp_clk) begin
        if (RESET) begin
            state    <= ST_IDLE;
            pkt_ts   <= '0;
            err_cnt  <= '0;
            late_cnt <= '0;
            pkt_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if ((state == ST_IDLE) && acc) begin
                pkt_ts[TSF_W-1 -: 32] <= s_axis_tdata;
            end
            if ((state == ST_HDR_LO) && acc) begin
                pkt_ts[31:0] <= s_axis_tdata;
            end
            if (err_inc && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
            if (late_inc && (late_cnt != 16'hFFFF)) begin
                late_cnt <= late_cnt + 16'd1;
            end
            if (pkt_inc) begin
                pkt_cnt <= pkt_cnt + 32'd1;
            end
        end
    end

    always_comb begin
        status = '0;
        status[STAT_STATE_LSB +: 3] = state;
        status[STAT_BUSY]           = (state != ST_IDLE);
        status[STAT_ERR_LSB +: 8]   = err_cnt;
        status[STAT_LATE_LSB +: 16] = late_cnt;
    end

endmodule

`default_nettype wire

// File: tb/tb_vita49_tx_timegate.sv
// ============================================================================
// Module      : tb_vita49_tx_timegate
// Description : Scoreboard bench for vita49_tx_timegate (LATE_MODE 0 and 1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_vita49_tx_timegate;

    logic        samp_clk = 1'b0;
    logic        RESET    = 1'b1;
    logic [31:0] ctrl     = 32'd0;
    logic [63:0] tsf      = 64'd0;
    logic [31:0] s_tdata  = 32'd0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast  = 1'b0;
    logic        m_tready = 1'b1;
    logic        sel      = 1'b0;
    logic        tsf_run  = 1'b0;
    logic        bp       = 1'b0;
    logic        chk_mirror = 1'b0;
    logic        seen_valid = 1'b0;
    logic [63:0] first_tsf  = 64'd0;

    int n_vec = 0;
    int n_bad = 0;

    logic [32:0] sb[$];
    logic [32:0] exp_w;

    always #10 samp_clk = ~samp_clk;

    logic        s_tready0, s_tready1, m_tvalid0, m_tvalid1, m_tlast0, m_tlast1;
    logic [31:0] m_tdata0, m_tdata1, status0, status1, pkt_cnt0, pkt_cnt1;
    logic        s_tvalid0, s_tvalid1, m_tready0, m_tready1;

    assign s_tvalid0 = s_tvalid && !sel;
    assign s_tvalid1 = s_tvalid && sel;
    assign m_tready0 = m_tready && !sel;
    assign m_tready1 = m_tready && sel;

    logic        s_tready_s, m_tvalid_s, m_tlast_s;
    logic [31:0] m_tdata_s, status_s, pkt_cnt_s;

    assign s_tready_s = sel ? s_tready1 : s_tready0;
    assign m_tvalid_s = sel ? m_tvalid1 : m_tvalid0;
    assign m_tlast_s  = sel ? m_tlast1  : m_tlast0;
    assign m_tdata_s  = sel ? m_tdata1  : m_tdata0;
    assign status_s   = sel ? status1   : status0;
    assign pkt_cnt_s  = sel ? pkt_cnt1  : pkt_cnt0;

    vita49_tx_timegate #(.LATE_MODE(1'b0)) dut0 (
        .samp_clk(samp_clk), .RESET(RESET), .ctrl(ctrl), .tsf(tsf),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid0), .s_axis_tready(s_tready0),
        .s_axis_tlast(s_tlast), .m_axis_tdata(m_tdata0), .m_axis_tvalid(m_tvalid0),
        .m_axis_tready(m_tready0), .m_axis_tlast(m_tlast0), .status(status0),
        .pkt_cnt(pkt_cnt0)
    );

    vita49_tx_timegate #(.LATE_MODE(1'b1)) dut1 (
        .samp_clk(samp_clk), .RESET(RESET), .ctrl(ctrl), .tsf(tsf),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid1), .s_axis_tready(s_tready1),
        .s_axis_tlast(s_tlast), .m_axis_tdata(m_tdata1), .m_axis_tvalid(m_tvalid1),
        .m_axis_tready(m_tready1), .m_axis_tlast(m_tlast1), .status(status1),
        .pkt_cnt(pkt_cnt1)
    );

    // Output monitor: samples settled signals just before each active edge.
    always begin
        @(negedge samp_clk);
        #4;
        if (m_tvalid_s && !seen_valid) begin
            seen_valid = 1'b1;
            first_tsf  = tsf;
        end
        if (m_tvalid_s && m_tready) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL out_word: got last=%b data=%h, expected no output", m_tlast_s, m_tdata_s);
            end else begin
                exp_w = sb.pop_front();
                if ({m_tlast_s, m_tdata_s} !== exp_w) begin
                    n_bad++;
                    $display("FAIL out_word: got last=%b data=%h, expected last=%b data=%h",
                             m_tlast_s, m_tdata_s, exp_w[32], exp_w[31:0]);
                end
            end
        end
        if (chk_mirror && (status_s[2:0] == 3'd4)) begin
            n_vec++;
            if (s_tready_s !== m_tready) begin
                n_bad++;
                $display("FAIL tready_mirror: s_tready=%b m_tready=%b", s_tready_s, m_tready);
            end
        end
    end

    task automatic cyc();
        @(negedge samp_clk);
        if (tsf_run) tsf = tsf + 64'd1;
        if (bp) m_tready = ~m_tready;
    endtask

    task automatic do_reset(input logic [63:0] t0);
        tsf = t0; tsf_run = 1'b1; RESET = 1'b1; ctrl = 32'd0;
        s_tvalid = 1'b0; s_tlast = 1'b0; bp = 1'b0; m_tready = 1'b1;
        repeat (3) cyc();
        RESET = 1'b0; ctrl = 32'd1;
        seen_valid = 1'b0;
        sb.delete();
    endtask

    task automatic put_word(input logic [31:0] d, input logic last, output int stalls);
        bit done;
        done = 1'b0;
        stalls = 0;
        s_tdata = d; s_tlast = last; s_tvalid = 1'b1;
        for (int k = 0; k < 3000 && !done; k++) begin
            #4;
            if (s_tready_s) done = 1'b1;
            else stalls++;
            cyc();
        end
        if (!done) begin
            n_vec++; n_bad++;
            $display("FAIL accept_timeout: word %h not accepted, required accept within 3000 cycles", d);
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic send_pkt(input logic [63:0] ts, input int n, input logic [31:0] base,
                            input bit expect_out, output int pay_stalls);
        int st;
        put_word(ts[63:32], 1'b0, st);
        put_word(ts[31:0], 1'b0, st);
        pay_stalls = 0;
        for (int i = 0; i < n; i++) begin
            if (expect_out) sb.push_back({(i == n - 1), base + 32'(i)});
            put_word(base + 32'(i), (i == n - 1), st);
            if (i > 0) pay_stalls += st;
        end
    endtask

    task automatic test_reset();
        sel = 1'b0; tsf_run = 1'b0; RESET = 1'b1; ctrl = 32'd1;
        s_tvalid = 1'b1; s_tdata = 32'hDEAD_BEEF; s_tlast = 1'b1;
        cyc(); cyc(); #2;
        n_vec++; if (s_tready_s !== 1'b0)  begin n_bad++; $display("FAIL rst_s_tready: got %b need 0", s_tready_s); end
        n_vec++; if (m_tvalid_s !== 1'b0)  begin n_bad++; $display("FAIL rst_m_tvalid: got %b need 0", m_tvalid_s); end
        n_vec++; if (m_tdata_s !== 32'd0)  begin n_bad++; $display("FAIL rst_m_tdata: got %h need 0", m_tdata_s); end
        n_vec++; if (m_tlast_s !== 1'b0)   begin n_bad++; $display("FAIL rst_m_tlast: got %b need 0", m_tlast_s); end
        n_vec++; if (status_s !== 32'd0)   begin n_bad++; $display("FAIL rst_status: got %h need 0", status_s); end
        n_vec++; if (pkt_cnt_s !== 32'd0)  begin n_bad++; $display("FAIL rst_pkt_cnt: got %0d need 0", pkt_cnt_s); end
        s_tvalid = 1'b0; s_tlast = 1'b0; ctrl = 32'd0;
        cyc(); RESET = 1'b0; cyc(); #2;
        n_vec++; if (s_tready_s !== 1'b0)  begin n_bad++; $display("FAIL disabled_tready: got %b need 0", s_tready_s); end
        n_vec++; if (status_s !== 32'd0)   begin n_bad++; $display("FAIL idle_status: got %h need 0", status_s); end
        ctrl = 32'd1; #1;
        n_vec++; if (s_tready_s !== 1'b1)  begin n_bad++; $display("FAIL enabled_tready: got %b need 1", s_tready_s); end
    endtask

    task automatic test_on_time();
        int st;
        sel = 1'b0; do_reset(64'd100);
        send_pkt(64'd200, 4, 32'hA000_0000, 1'b1, st);
        cyc(); #2;
        n_vec++; if ((first_tsf - 64'd1) !== 64'd198) begin n_bad++; $display("FAIL ontime_first_valid: tsf_r=%0d need 198", first_tsf - 64'd1); end
        n_vec++; if (pkt_cnt_s !== 32'd1)  begin n_bad++; $display("FAIL ontime_pkt_cnt: got %0d need 1", pkt_cnt_s); end
        n_vec++; if (status_s !== 32'd0)   begin n_bad++; $display("FAIL ontime_status: got %h need 0", status_s); end
        n_vec++; if (sb.size() != 0)       begin n_bad++; $display("FAIL ontime_drain: %0d words missing, need 0", sb.size()); end
    endtask

    task automatic test_late();
        int st;
        sel = 1'b0; do_reset(64'd500);
        send_pkt(64'd300, 3, 32'hB000_0000, 1'b0, st);
        cyc(); #2;
        n_vec++; if (st != 0)                      begin n_bad++; $display("FAIL late0_stalls: got %0d need 0", st); end
        n_vec++; if (status_s !== 32'h0001_0000)   begin n_bad++; $display("FAIL late0_status: got %h need 00010000", status_s); end
        n_vec++; if (pkt_cnt_s !== 32'd0)          begin n_bad++; $display("FAIL late0_pkt_cnt: got %0d need 0", pkt_cnt_s); end
        sel = 1'b1; do_reset(64'd500);
        send_pkt(64'd300, 3, 32'hB100_0000, 1'b1, st);
        cyc(); #2;
        n_vec++; if (st != 0)                      begin n_bad++; $display("FAIL late1_stalls: got %0d need 0", st); end
        n_vec++; if (status_s !== 32'h0001_0000)   begin n_bad++; $display("FAIL late1_status: got %h need 00010000", status_s); end
        n_vec++; if (pkt_cnt_s !== 32'd1)          begin n_bad++; $display("FAIL late1_pkt_cnt: got %0d need 1", pkt_cnt_s); end
        n_vec++; if (sb.size() != 0)               begin n_bad++; $display("FAIL late1_drain: %0d words missing, need 0", sb.size()); end
        sel = 1'b0;
    endtask

    task automatic test_too_early();
        int st;
        sel = 1'b0; do_reset(64'd0);
        send_pkt(64'h1000_0000 + 64'd10, 3, 32'hC000_0000, 1'b0, st);
        cyc(); #2;
        n_vec++; if (status_s !== 32'h0000_0100)   begin n_bad++; $display("FAIL early_status: got %h need 00000100", status_s); end
        send_pkt(tsf + 64'd20, 2, 32'hC100_0000, 1'b1, st);
        cyc(); #2;
        n_vec++; if (pkt_cnt_s !== 32'd1)          begin n_bad++; $display("FAIL early_next_pkt: got %0d need 1", pkt_cnt_s); end
        n_vec++; if (status_s !== 32'h0000_0100)   begin n_bad++; $display("FAIL early_next_status: got %h need 00000100", status_s); end
        n_vec++; if (sb.size() != 0)               begin n_bad++; $display("FAIL early_drain: %0d words missing, need 0", sb.size()); end
    endtask

    task automatic test_backpressure();
        int st;
        sel = 1'b0; do_reset(64'd1000);
        bp = 1'b1; chk_mirror = 1'b1;
        send_pkt(64'd1010, 6, 32'hD000_0000, 1'b1, st);
        bp = 1'b0; chk_mirror = 1'b0; m_tready = 1'b1;
        cyc(); #2;
        n_vec++; if (pkt_cnt_s !== 32'd1)  begin n_bad++; $display("FAIL bp_pkt_cnt: got %0d need 1", pkt_cnt_s); end
        n_vec++; if (sb.size() != 0)       begin n_bad++; $display("FAIL bp_drain: %0d words missing, need 0", sb.size()); end
    endtask

    task automatic test_malformed();
        int st;
        sel = 1'b0; do_reset(64'd50);
        put_word(32'd0, 1'b0, st);
        put_word(32'd5, 1'b1, st);
        cyc(); #2;
        n_vec++; if (status_s !== 32'h0000_0100)   begin n_bad++; $display("FAIL hdr_tlast_status: got %h need 00000100", status_s); end
        put_word(32'd0, 1'b0, st);
        put_word(32'd5000, 1'b0, st);
        cyc(); cyc(); #2;
        n_vec++; if (status_s[2:0] !== 3'd3)       begin n_bad++; $display("FAIL flush_pre_state: got %0d need 3", status_s[2:0]); end
        ctrl = 32'd3;
        cyc(); ctrl = 32'd1; #2;
        n_vec++; if (status_s[3:0] !== 4'hD)       begin n_bad++; $display("FAIL flush_drop_state: got %h need D", status_s[3:0]); end
        for (int i = 0; i < 3; i++) put_word(32'hF000_0000 + 32'(i), (i == 2), st);
        cyc(); #2;
        n_vec++; if (status_s !== 32'h0000_0100)   begin n_bad++; $display("FAIL flush_end_status: got %h need 00000100", status_s); end
        n_vec++; if (pkt_cnt_s !== 32'd0)          begin n_bad++; $display("FAIL flush_pkt_cnt: got %0d need 0", pkt_cnt_s); end
    endtask

    task automatic test_reset_mid_stream();
        int st;
        logic [63:0] ts;
        sel = 1'b0; do_reset(64'd2000);
        ts = tsf + 64'd30;
        put_word(ts[63:32], 1'b0, st);
        put_word(ts[31:0], 1'b0, st);
        for (int i = 0; i < 3; i++) begin
            sb.push_back({1'b0, 32'hE000_0000 + 32'(i)});
            put_word(32'hE000_0000 + 32'(i), 1'b0, st);
        end
        s_tdata = 32'hE000_0003; s_tlast = 1'b1; s_tvalid = 1'b1; RESET = 1'b1;
        cyc(); #2;
        n_vec++; if (s_tready_s !== 1'b0)  begin n_bad++; $display("FAIL midrst_s_tready: got %b need 0", s_tready_s); end
        n_vec++; if (m_tvalid_s !== 1'b0)  begin n_bad++; $display("FAIL midrst_m_tvalid: got %b need 0", m_tvalid_s); end
        n_vec++; if (m_tdata_s !== 32'd0)  begin n_bad++; $display("FAIL midrst_m_tdata: got %h need 0", m_tdata_s); end
        n_vec++; if (m_tlast_s !== 1'b0)   begin n_bad++; $display("FAIL midrst_m_tlast: got %b need 0", m_tlast_s); end
        n_vec++; if (status_s !== 32'd0)   begin n_bad++; $display("FAIL midrst_status: got %h need 0", status_s); end
        n_vec++; if (sb.size() != 0)       begin n_bad++; $display("FAIL midrst_drain: %0d words missing, need 0", sb.size()); end
        s_tvalid = 1'b0; s_tlast = 1'b0; RESET = 1'b0;
        cyc();
        send_pkt(tsf + 64'd10, 3, 32'hE100_0000, 1'b1, st);
        cyc(); #2;
        n_vec++; if (pkt_cnt_s !== 32'd1)  begin n_bad++; $display("FAIL midrst_next_pkt: got %0d need 1", pkt_cnt_s); end
        n_vec++; if (sb.size() != 0)       begin n_bad++; $display("FAIL midrst_next_drain: %0d words missing, need 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_on_time();
        test_late();
        test_too_early();
        test_backpressure();
        test_malformed();
        test_reset_mid_stream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
